swap_arbiter: RTL

SWAP_ARBITER -- requirements
Module: swap_arbiter

---
 rtl/swap_pkg.sv | 13 +
 rtl/swap_unit.sv | 22 ++
 rtl/swap_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/swap_pkg.sv
// Shared types for the swap arbiter: byte-transform mode encodings.
// Latency: none (types only).
// Backpressure: not applicable.
package swap_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_REV     = 2'b01,
        MODE_HSWAP   = 2'b10,
        MODE_BSWAP16 = 2'b11
    } mode_t;

endpackage

// File: rtl/swap_unit.sv
// Byte/halfword permutation of one 32-bit word selected by mode.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module swap_unit
    import swap_pkg::*;
(
    input  logic [31:0] data,
    input  mode_t       mode,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (mode)
            MODE_REV:     result = {data[7:0], data[15:8], data[23:16], data[31:24]};
            MODE_HSWAP:   result = {data[15:0], data[31:16]};
            MODE_BSWAP16: result = {data[23:16], data[31:24], data[7:0], data[15:8]};
            default:      result = data;
        endcase
    end

endmodule

// File: rtl/swap_arbiter.sv
// Two-requester round-robin arbiter feeding one registered byte-swap stage.
// Latency: 1 cycle from accepted request to out_valid.
// Backpressure: ready only when the output register is empty or draining this cycle.
module swap_arbiter
    import swap_pkg::*;
#(
    parameter bit RR_INIT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [1:0]       req1_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    logic        prio;
    logic        can_load;
    logic        grant0;
    logic        grant1;
    logic        xfer0;
    logic        xfer1;
    logic [31:0] sel_data;
    mode_t       sel_mode;
    logic [31:0] swapped;

    assign can_load = !out_valid || out_ready;

    // Contention is settled by prio; a lone requester always wins.
    assign grant0 = req0_valid && (!req1_valid || (prio == 1'b0));
    assign grant1 = req1_valid && (!req0_valid || (prio == 1'b1));

    assign req0_ready = rst_n && can_load && grant0;
    assign req1_ready = rst_n && can_load && grant1;

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_mode = grant1 ? mode_t'(req1_mode) : mode_t'(req0_mode);

    swap_unit u_swap (
        .data   (sel_data),
        .mode   (sel_mode),
        .result (swapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (xfer0 || xfer1) begin
            out_valid <= 1'b1;
            out_data  <= swapped;
            out_src   <= xfer1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= RR_INIT;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (xfer0) begin
                prio       <= 1'b1;
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (xfer1) begin
                prio       <= 1'b0;
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
